ctrl_datapath_exec: RTL and testbench
=====================================

// Module: ctrl_datapath_exec
// PURPOSE
//  Downstream consumer of the microcoded control sequencer: accepts one control word per
//  handshake and executes it on the register/bus datapath (AC, R, PC, AR, DR, ALU).
//  Drives a req/ack memory port for DR loads and stores; returns Z/C flags and a halt
//  status to the sequencer for branching. Single clock domain, same clock as the sequencer.
// PARAMETERS
//  DW  8  datapath width (AC, R, DR, bus, mem data)
//  AW  8  address width (PC, AR, mem_addr); bus[AW-1:0] loads PC/AR, PC/AR zero-extend onto bus
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst        in   1   synchronous reset, active high
//  cw_valid   in   1   control word valid from sequencer
//  cw         in   16  control word (format below)
//  cw_ready   out  1   block accepts cw this cycle (=1 only in IDLE and rst low)
//  mem_req    out  1   memory request, held until mem_ack
//  mem_we     out  1   1=write DR to mem_addr, 0=read into DR
//  mem_addr   out  AW  = AR latched at request start
//  mem_wdata  out  DW  = DR latched at request start
//  mem_rdata  in   DW  read data, valid when mem_ack & ~mem_we
//  mem_ack    in   1   one-cycle completion pulse
//  ac_out     out  DW  accumulator
//  pc_out     out  AW  program counter
//  z_flag     out  1   registered: AC==0 after last AC update
//  c_flag     out  1   registered carry/borrow of last add/sub/inc/shl
//  halted     out  1   sticky halt indicator
// BEHAVIOUR
//  cw fields: [15:13] bus_src 0=zero 1=AC 2=R 3=PC 4=AR 5=DR 6,7=zero; [12:8] ld {AC,R,PC,AR,DR};
//   [7:5] alu_op; [4] pc_inc; [3] mem_rd; [2] mem_wr; [1] clr_ac; [0] halt.
//  Accept = cw_valid & cw_ready. All register loads of an accepted word happen at that edge.
//  ALU (applies when ld_AC): 0 AC<=bus 1 AC+bus 2 AC-bus 3 AND 4 OR 5 XOR 6 AC+1 7 AC<<1;
//   results mod 2^DW; C = carry-out (add/inc), borrow (sub), old AC[DW-1] (shl), else C kept.
//   Z updated whenever AC is written (incl. clr_ac); else held.
//  Priority: clr_ac over ld_AC (AC<=0, Z<=1, C held); ld_PC over pc_inc; pc_inc wraps 2^AW-1->0.
//  FSM IDLE/MEM/HALT. Reset -> IDLE.
//   IDLE: accept; if mem_rd|mem_wr -> MEM, latch mem_addr=AR and mem_wdata=DR *after* this word's
//    loads (new values), mem_req=1 next cycle. mem_rd&mem_wr both set -> read only.
//    If halt (and no mem op) -> HALT. halt with mem op -> MEM, then HALT after ack.
//   MEM: cw_ready=0, mem_req/we/addr/wdata stable; on mem_ack: read -> DR<=mem_rdata;
//    mem_req=0 same edge; next state IDLE (or HALT if pending). No timeout.
//   HALT: cw_ready=0, halted=1, all registers frozen; exit only by rst.
//  Memory op latency: accept edge -> mem_req high next cycle -> IDLE cycle after ack.
//  Non-memory word: 1 cycle, back-to-back words accepted every cycle.
//  cw ignored when cw_valid=0 or cw_ready=0 (no side effects).
//  Reset (any state, incl. mid-MEM): AC,R,PC,AR,DR,Z,C,halted,mem_req,mem_we=0, addr/wdata=0;
//   mem_ack arriving during/after reset ignored; cw_ready=1 first cycle after rst falls.
// TESTING
//  1 Reset: rst 1 cycle mid-MEM -> mem_req=0, all regs 0, cw_ready=1 next cycle.
//  2 ALU/flags: AC=8'hFF, R=8'h01; bus=R, ld_AC, op=1 -> AC=00, Z=1, C=1; op=2 then -> AC=FF, C=1.
//  3 Read: AR=8'h20, cw mem_rd; ack after 3 cycles with rdata=8'h5A -> DR=5A, cw_ready low 4 cycles.
//  4 Write+priority: DR=8'h33, mem_wr with ld_AR from bus=AC=8'h40 -> mem_addr=40, wdata=33, we=1.
//  5 PC: PC=8'hFF pc_inc -> 00; pc_inc+ld_PC bus=R=8'h10 -> PC=10; clr_ac+ld_AC -> AC=0, Z=1.
//  6 Halt: halt word -> halted=1, cw_ready=0, later cw_valid words leave AC/PC unchanged until rst.

Source files
------------

// File: rtl/ctrl_datapath_exec_if.sv
// ctrl_datapath_exec_if: control-word handshake, memory port and status bundle between sequencer and datapath
//   cw_valid/cw/cw_ready             control word handshake (sequencer -> datapath)
//   mem_req/we/addr/wdata/rdata/ack  req/ack memory port driven by the datapath
//   ac_out/pc_out/z_flag/c_flag      architectural state and flags returned to the sequencer
//   halted                           sticky halt status
interface ctrl_datapath_exec_if #(parameter int DW = 8, parameter int AW = 8);
  logic          cw_valid;
  logic [15:0]   cw;
  logic          cw_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [DW-1:0] ac_out;
  logic [AW-1:0] pc_out;
  logic          z_flag;
  logic          c_flag;
  logic          halted;
  modport master (
    output cw_valid, cw, mem_rdata, mem_ack,
    input  cw_ready, mem_req, mem_we, mem_addr, mem_wdata, ac_out, pc_out, z_flag, c_flag, halted
  );
  modport slave (
    input  cw_valid, cw, mem_rdata, mem_ack,
    output cw_ready, mem_req, mem_we, mem_addr, mem_wdata, ac_out, pc_out, z_flag, c_flag, halted
  );
endinterface

// File: rtl/ctrl_datapath_exec.sv
// ctrl_datapath_exec: executes one microcoded control word per handshake on the AC/R/PC/AR/DR/ALU datapath
//   clk  system clock, rising edge
//   rst  synchronous reset, active high
//   io   slave side of ctrl_datapath_exec_if (control word in, memory port, AC/PC/flags/halt out)
// Assumes AW <= DW: PC/AR zero-extend onto the bus and load from its low AW bits.
module ctrl_datapath_exec #(parameter int DW = 8, parameter int AW = 8) (
  input logic clk,
  input logic rst,
  ctrl_datapath_exec_if.slave io
);
  typedef enum logic [1:0] {IDLE, MEM, HALT} state_t;
  state_t        r_state, w_next;
  logic [DW-1:0] r_ac, r_r, r_dr, r_mem_wdata;
  logic [AW-1:0] r_pc, r_ar, r_mem_addr;
  logic          r_z, r_c, r_mem_we, r_halt_pend;
  logic [2:0]    w_src, w_op;
  logic          w_ld_ac, w_ld_r, w_ld_pc, w_ld_ar, w_ld_dr;
  logic          w_pc_inc, w_mem_rd, w_mem_wr, w_clr, w_halt, w_accept;
  logic [DW-1:0] w_bus, w_dr_next;
  logic [AW-1:0] w_ar_next;
  logic [DW:0]   w_alu;
  assign {w_src, w_ld_ac, w_ld_r, w_ld_pc, w_ld_ar, w_ld_dr, w_op, w_pc_inc, w_mem_rd, w_mem_wr, w_clr, w_halt} = io.cw;
  assign w_accept = io.cw_valid & io.cw_ready;
  always_comb
    w_bus = w_src == 3'd1 ? r_ac :
            w_src == 3'd2 ? r_r :
            w_src == 3'd3 ? DW'(r_pc) :
            w_src == 3'd4 ? DW'(r_ar) :
            w_src == 3'd5 ? r_dr : '0;
  // Top bit is the new carry; ops that leave C alone carry the old r_c through.
  always_comb begin
    w_alu = {r_c, w_bus};
    case (w_op)
      3'd1:    w_alu = {1'b0, r_ac} + {1'b0, w_bus};
      3'd2:    w_alu = {1'b0, r_ac} - {1'b0, w_bus};
      3'd3:    w_alu = {r_c, r_ac & w_bus};
      3'd4:    w_alu = {r_c, r_ac | w_bus};
      3'd5:    w_alu = {r_c, r_ac ^ w_bus};
      3'd6:    w_alu = {1'b0, r_ac} + (DW+1)'(1);
      3'd7:    w_alu = {r_ac, 1'b0};
      default: w_alu = {r_c, w_bus};
    endcase
  end
  // Memory address/data are taken from AR/DR as they stand after this word's own loads.
  assign w_ar_next = w_ld_ar ? w_bus[AW-1:0] : r_ar;
  assign w_dr_next = w_ld_dr ? w_bus : r_dr;
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_accept) w_next = (w_mem_rd | w_mem_wr) ? MEM : w_halt ? HALT : IDLE;
    else if (r_state == MEM && io.mem_ack) w_next = r_halt_pend ? HALT : IDLE;
  end
  always_comb begin
    io.cw_ready = r_state == IDLE && !rst;
    io.mem_req  = r_state == MEM;
    io.halted   = r_state == HALT;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_ac        <= '0;
      r_r         <= '0;
      r_pc        <= '0;
      r_ar        <= '0;
      r_dr        <= '0;
      r_z         <= 1'b0;
      r_c         <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_halt_pend <= 1'b0;
    end else if (w_accept) begin
      if (w_clr) begin
        r_ac <= '0;
        r_z  <= 1'b1;
      end else if (w_ld_ac) begin
        r_ac <= w_alu[DW-1:0];
        r_z  <= w_alu[DW-1:0] == '0;
        r_c  <= w_alu[DW];
      end
      if (w_ld_r) r_r <= w_bus;
      r_pc <= w_ld_pc ? w_bus[AW-1:0] : r_pc + AW'(w_pc_inc);
      r_ar <= w_ar_next;
      r_dr <= w_dr_next;
      if (w_mem_rd | w_mem_wr) begin
        r_mem_addr  <= w_ar_next;
        r_mem_wdata <= w_dr_next;
        r_mem_we    <= ~w_mem_rd;
        r_halt_pend <= w_halt;
      end
    end else if (r_state == MEM && io.mem_ack && !r_mem_we) r_dr <= io.mem_rdata;
  assign io.mem_we    = r_mem_we;
  assign io.mem_addr  = r_mem_addr;
  assign io.mem_wdata = r_mem_wdata;
  assign io.ac_out    = r_ac;
  assign io.pc_out    = r_pc;
  assign io.z_flag    = r_z;
  assign io.c_flag    = r_c;
endmodule

// File: tb/tb_ctrl_datapath_exec.sv
// tb_ctrl_datapath_exec: table vectors, directed multi-cycle sequences and random stimulus against a reference model
module tb_ctrl_datapath_exec;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  int m_ac, m_r, m_pc, m_ar, m_dr, m_z, m_c, m_busy, m_we, m_addr, m_wdata, m_halt_after, m_halted;
  ctrl_datapath_exec_if #(.DW(8), .AW(8)) cp();
  ctrl_datapath_exec #(.DW(8), .AW(8)) dut (.clk(clk), .rst(rst), .io(cp));
  always #5 clk = ~clk;
  localparam int LAC = 16, LR = 8, LPC = 4, LAR = 2, LDR = 1;
  typedef struct {
    int          v;
    logic [15:0] cw;
    int          ac, pc, z, c;
  } vec_t;
  vec_t tbl[20];
  function automatic logic [15:0] cwf(input int s, ld, op, inc, rd, wr, clr, h);
    cwf = {s[2:0], ld[4:0], op[2:0], inc[0], rd[0], wr[0], clr[0], h[0]};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: architectural effect of one cycle, from the control-word rules in plain integer arithmetic.
  task automatic model(input int r, input int v, input logic [15:0] w, input int a, input int d);
    int bus, t, s;
    if (r != 0) begin
      {m_ac, m_r, m_pc, m_ar, m_dr, m_z, m_c} = '0;
      {m_busy, m_we, m_addr, m_wdata, m_halt_after, m_halted} = '0;
    end else if (m_halted != 0) begin
    end else if (m_busy != 0) begin
      if (a != 0) begin
        if (m_we == 0) m_dr = d;
        m_busy = 0;
        m_halted = m_halt_after;
      end
    end else if (v != 0) begin
      s = int'(w[15:13]);
      bus = s == 1 ? m_ac : s == 2 ? m_r : s == 3 ? m_pc : s == 4 ? m_ar : s == 5 ? m_dr : 0;
      if (w[1]) begin
        m_ac = 0;
        m_z = 1;
      end else if (w[12]) begin
        case (int'(w[7:5]))
          1: begin t = m_ac + bus; m_c = int'(t > 255); end
          2: begin t = m_ac - bus; m_c = int'(t < 0); end
          3: t = m_ac & bus;
          4: t = m_ac | bus;
          5: t = m_ac ^ bus;
          6: begin t = m_ac + 1; m_c = int'(t > 255); end
          7: begin t = m_ac * 2; m_c = int'(t > 255); end
          default: t = bus;
        endcase
        m_ac = (t + 256) % 256;
        m_z = int'(m_ac == 0);
      end
      if (w[11]) m_r = bus;
      if (w[10]) m_pc = bus;
      else if (w[4]) m_pc = (m_pc + 1) % 256;
      if (w[9]) m_ar = bus;
      if (w[8]) m_dr = bus;
      if (w[3] | w[2]) begin
        m_busy = 1;
        m_we = int'(!w[3]);
        m_addr = m_ar;
        m_wdata = m_dr;
        m_halt_after = int'(w[0]);
      end else if (w[0]) m_halted = 1;
    end
  endtask
  task automatic tick(input int r, input int v, input logic [15:0] w, input int a, input int d);
    rst = r != 0;
    cp.cw_valid = v != 0;
    cp.cw = w;
    cp.mem_ack = a != 0;
    cp.mem_rdata = d[7:0];
    model(r, v, w, a, d);
    @(posedge clk);
    #1;
  endtask
  task automatic chk_model();
    chk("m_ac", cp.ac_out, m_ac);
    chk("m_pc", cp.pc_out, m_pc);
    chk("m_z", cp.z_flag, m_z);
    chk("m_c", cp.c_flag, m_c);
    chk("m_halted", cp.halted, m_halted);
    chk("m_ready", cp.cw_ready, int'(!rst && m_busy == 0 && m_halted == 0));
    chk("m_req", cp.mem_req, m_busy);
    if (m_busy != 0) begin
      chk("m_we", cp.mem_we, m_we);
      chk("m_addr", cp.mem_addr, m_addr);
      chk("m_wdata", cp.mem_wdata, m_wdata);
    end
  endtask
  initial begin
    int low;
    int r, v, a;
    logic [15:0] w;
    tbl[0]  = '{1, cwf(0, LAC, 6, 0, 0, 0, 0, 0), 8'h01, 8'h00, 0, 0};
    tbl[1]  = '{1, cwf(1, LR,  0, 0, 0, 0, 0, 0), 8'h01, 8'h00, 0, 0};
    tbl[2]  = '{1, cwf(1, LAC, 2, 0, 0, 0, 0, 0), 8'h00, 8'h00, 1, 0};
    tbl[3]  = '{1, cwf(2, LAC, 2, 0, 0, 0, 0, 0), 8'hFF, 8'h00, 0, 1};
    tbl[4]  = '{1, cwf(2, LAC, 1, 0, 0, 0, 0, 0), 8'h00, 8'h00, 1, 1};
    tbl[5]  = '{1, cwf(2, LAC, 2, 0, 0, 0, 0, 0), 8'hFF, 8'h00, 0, 1};
    tbl[6]  = '{1, cwf(0, LAC, 7, 0, 0, 0, 0, 0), 8'hFE, 8'h00, 0, 1};
    tbl[7]  = '{1, cwf(2, LAC, 3, 0, 0, 0, 0, 0), 8'h00, 8'h00, 1, 1};
    tbl[8]  = '{1, cwf(2, LAC, 4, 0, 0, 0, 0, 0), 8'h01, 8'h00, 0, 1};
    tbl[9]  = '{1, cwf(2, LAC, 5, 0, 0, 0, 0, 0), 8'h00, 8'h00, 1, 1};
    tbl[10] = '{1, cwf(0, LAC, 6, 0, 0, 0, 0, 0), 8'h01, 8'h00, 0, 0};
    tbl[11] = '{1, cwf(2, LPC, 0, 0, 0, 0, 0, 0), 8'h01, 8'h01, 0, 0};
    tbl[12] = '{0, cwf(0, LAC, 0, 1, 0, 0, 1, 0), 8'h01, 8'h01, 0, 0};
    tbl[13] = '{1, cwf(0, LAC, 0, 0, 0, 0, 0, 0), 8'h00, 8'h01, 1, 0};
    tbl[14] = '{1, cwf(2, LAC, 2, 0, 0, 0, 0, 0), 8'hFF, 8'h01, 0, 1};
    tbl[15] = '{1, cwf(1, LPC, 0, 0, 0, 0, 0, 0), 8'hFF, 8'hFF, 0, 1};
    tbl[16] = '{1, cwf(0, 0,   0, 1, 0, 0, 0, 0), 8'hFF, 8'h00, 0, 1};
    tbl[17] = '{1, cwf(2, LPC, 0, 1, 0, 0, 0, 0), 8'hFF, 8'h01, 0, 1};
    tbl[18] = '{1, cwf(2, LAC, 1, 0, 0, 0, 1, 0), 8'h00, 8'h01, 1, 1};
    tbl[19] = '{1, cwf(0, 0,   0, 1, 0, 0, 0, 0), 8'h00, 8'h02, 1, 1};
    cp.cw_valid = 1'b0;
    cp.cw = '0;
    cp.mem_ack = 1'b0;
    cp.mem_rdata = '0;
    tick(1, 0, 0, 0, 0);
    chk("rst_ready", cp.cw_ready, 0);
    tick(0, 0, 0, 0, 0);
    chk("rst_ac", cp.ac_out, 0);
    chk("rst_pc", cp.pc_out, 0);
    chk("rst_zc", {cp.z_flag, cp.c_flag, cp.halted, cp.mem_req}, 0);
    chk("rst_ready_after", cp.cw_ready, 1);
    for (int i = 0; i < 20; i++) begin
      tick(0, tbl[i].v, tbl[i].cw, 0, 0);
      chk($sformatf("tbl%0d_ac", i), cp.ac_out, tbl[i].ac);
      chk($sformatf("tbl%0d_pc", i), cp.pc_out, tbl[i].pc);
      chk($sformatf("tbl%0d_z", i), cp.z_flag, tbl[i].z);
      chk($sformatf("tbl%0d_c", i), cp.c_flag, tbl[i].c);
      chk($sformatf("tbl%0d_rdy", i), {cp.cw_ready, cp.mem_req, cp.halted}, 3'b100);
    end
    tick(0, 1, cwf(0, LAC, 6, 0, 0, 0, 0, 0), 0, 0);
    repeat (5) tick(0, 1, cwf(0, LAC, 7, 0, 0, 0, 0, 0), 0, 0);
    chk("rd_ac20", cp.ac_out, 8'h20);
    tick(0, 1, cwf(1, LAR, 0, 0, 0, 0, 0, 0), 0, 0);
    tick(0, 1, cwf(0, 0, 0, 0, 1, 0, 0, 0), 0, 0);
    chk("rd_req", cp.mem_req, 1);
    chk("rd_addr", cp.mem_addr, 8'h20);
    chk("rd_we", cp.mem_we, 0);
    low = int'(!cp.cw_ready);
    repeat (3) begin
      tick(0, 1, cwf(0, LAC, 0, 1, 0, 0, 1, 0), 0, 0);
      low += int'(!cp.cw_ready);
      chk("rd_req_held", cp.mem_req, 1);
    end
    tick(0, 1, cwf(0, LAC, 0, 1, 0, 0, 1, 0), 1, 8'h5A);
    chk("rd_low_cycles", low, 4);
    chk("rd_done", {cp.cw_ready, cp.mem_req}, 2'b10);
    chk("rd_ignored", {cp.ac_out, cp.pc_out}, 16'h2002);
    tick(0, 1, cwf(5, LAC, 0, 0, 0, 0, 0, 0), 0, 0);
    chk("rd_dr", cp.ac_out, 8'h5A);
    tick(0, 1, cwf(0, 0, 0, 0, 1, 0, 0, 0), 0, 0);
    tick(0, 0, 0, 1, 8'h33);
    tick(0, 1, cwf(4, LAC, 0, 0, 0, 0, 0, 0), 0, 0);
    tick(0, 1, cwf(0, LAC, 7, 0, 0, 0, 0, 0), 0, 0);
    chk("wr_ac40", cp.ac_out, 8'h40);
    tick(0, 1, cwf(1, LAR, 0, 0, 0, 1, 0, 0), 0, 0);
    chk("wr_addr", cp.mem_addr, 8'h40);
    chk("wr_wdata", cp.mem_wdata, 8'h33);
    chk("wr_we_req", {cp.mem_we, cp.mem_req, cp.cw_ready}, 3'b110);
    tick(0, 0, 0, 1, 8'hEE);
    chk("wr_done", {cp.cw_ready, cp.mem_req}, 2'b10);
    tick(0, 1, cwf(0, 0, 0, 0, 1, 1, 0, 0), 0, 0);
    chk("rdwr_we", {cp.mem_we, cp.mem_req}, 2'b01);
    tick(0, 0, 0, 1, 8'h77);
    tick(0, 1, cwf(5, LAC, 0, 0, 0, 0, 0, 0), 0, 0);
    chk("rdwr_dr", cp.ac_out, 8'h77);
    tick(0, 1, cwf(0, 0, 0, 0, 1, 0, 0, 0), 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 8'hAA);
    chk("midmem_req", cp.mem_req, 0);
    chk("midmem_regs", {cp.ac_out, cp.pc_out, cp.z_flag, cp.c_flag, cp.halted}, 0);
    tick(0, 0, 0, 0, 0);
    chk("midmem_ready", {cp.cw_ready, cp.mem_req}, 2'b10);
    tick(0, 1, cwf(5, LAC, 0, 0, 0, 0, 0, 0), 0, 0);
    chk("midmem_dr", {cp.ac_out, cp.z_flag}, 9'h001);
    tick(0, 1, cwf(0, LAC, 6, 0, 0, 0, 0, 0), 0, 0);
    tick(0, 1, cwf(0, LAC, 6, 1, 0, 0, 0, 1), 0, 0);
    chk("halt_state", {cp.halted, cp.cw_ready}, 2'b10);
    chk("halt_regs", {cp.ac_out, cp.pc_out}, 16'h0201);
    repeat (3) tick(0, 1, cwf(0, LAC, 6, 1, 0, 0, 0, 0), 0, 0);
    chk("halt_frozen", {cp.ac_out, cp.pc_out, cp.halted}, 17'h00403);
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk("halt_exit", {cp.halted, cp.cw_ready}, 2'b01);
    tick(0, 1, cwf(0, 0, 0, 0, 0, 1, 0, 1), 0, 0);
    chk("halt_mem_req", {cp.mem_req, cp.halted}, 2'b10);
    tick(0, 0, 0, 1, 0);
    chk("halt_mem_after", {cp.mem_req, cp.halted, cp.cw_ready}, 3'b010);
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, m_halted != 0 ? 7 : 199) == 0);
      v = int'($urandom_range(0, 3) != 0);
      w = 16'($urandom);
      if ($urandom_range(0, 29) != 0) w[0] = 1'b0;
      a = int'($urandom_range(0, 2) == 0);
      tick(r, v, w, a, int'($urandom_range(0, 255)));
      chk_model();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
